uart_rx_fifo: RTL and testbench

- Downstream consumer of the UART receiver stage.
- Owns the receiver's go / data / data_ready handshake and captures each received byte into a power-of-two synchronous FIFO.
- Presents bytes to the CPU / I/O bus as a first-word-fall-through valid/ready stream.
- Decouples CPU read latency from line rate, so bytes are not lost while software is busy.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: handshake FSM state encoding and the default byte width.
package uart_pkg;

   localparam int DataWidth = 8;

   typedef enum logic [1:0] {
      Init = 2'd0,
      Arm  = 2'd1,
      Ack  = 2'd2
   } uart_rx_fifo_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two synchronous FIFO with first-word-fall-through read and wrap-bit pointers.
module sync_fifo #(
   parameter int Depth     = 16,
   parameter int DataWidth = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [DataWidth-1:0]   wr_data,
   input  logic                   rd_en,
   output logic [DataWidth-1:0]   rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(Depth):0] count
);
   localparam int IdxW = $clog2(Depth);

   logic [IdxW:0]          wr_ptr_q, wr_ptr_d;
   logic [IdxW:0]          rd_ptr_q, rd_ptr_d;
   logic [DataWidth-1:0]   mem_q [Depth];
   logic                   push;
   logic                   pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                    (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q[IdxW-1:0]];
   assign count   = wr_ptr_q - rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{IdxW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{IdxW{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; contents are only observable once written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[IdxW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: go/data_ready handshake into a FWFT FIFO with sticky overrun.
// Optional saturating drop counter enabled by defining UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int Depth     = 16,
   parameter int DataWidth = uart_pkg::DataWidth
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   rx_go,
   input  logic [DataWidth-1:0]   rx_data,
   input  logic                   rx_data_ready,
   output logic [DataWidth-1:0]   out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(Depth):0] count,
   output logic                   overrun,
   input  logic                   overrun_clr,
`ifdef UART_RX_FIFO_DROP_CNT_EN
   output logic [7:0]             drop_count,
`endif
   output uart_rx_fifo_state_e    dbg_state
);
   uart_rx_fifo_state_e state_q, state_d;
   logic                rx_go_q, rx_go_d;
   logic                overrun_q, overrun_d;
   logic                push;
   logic                drop;
   logic                empty;
   logic                full;

   sync_fifo #(
      .Depth     (Depth),
      .DataWidth (DataWidth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (rx_data),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   // Capture happens in the Arm cycle: the receiver clears its data once go falls.
   always_comb begin
      state_d   = state_q;
      rx_go_d   = rx_go_q;
      overrun_d = overrun_q;
      push      = 1'b0;
      drop      = 1'b0;
      if (overrun_clr) overrun_d = 1'b0;
      case (state_q)
         Init: begin
            rx_go_d = 1'b1;
            state_d = Arm;
         end
         Arm: begin
            if (rx_data_ready) begin
               if (full) begin
                  drop      = 1'b1;
                  overrun_d = 1'b1;
               end else begin
                  push = 1'b1;
               end
               rx_go_d = 1'b0;
               state_d = Ack;
            end
         end
         Ack: begin
            if (!rx_data_ready) begin
               rx_go_d = 1'b1;
               state_d = Arm;
            end
         end
         default: begin
            rx_go_d = 1'b0;
            state_d = Init;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= Init;
         rx_go_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_go_q   <= rx_go_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef UART_RX_FIFO_DROP_CNT_EN
   logic [7:0] drop_count_q, drop_count_d;

   // A drop coinciding with a clear leaves exactly that one drop counted.
   always_comb begin
      drop_count_d = drop_count_q;
      if (drop) begin
         if (overrun_clr)                drop_count_d = 8'd1;
         else if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end else if (overrun_clr) begin
         drop_count_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) drop_count_q <= 8'd0;
      else     drop_count_q <= drop_count_d;
   end

   assign drop_count = drop_count_q;
`endif

   assign rx_go     = rx_go_q;
   assign overrun   = overrun_q;
   assign out_valid = !empty;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (Depth = 4) with a simple receiver handshake model.
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int Depth = 4;
   localparam int DW    = 8;
   localparam int CW    = $clog2(Depth) + 1;

   logic                clk;
   logic                rst;
   logic                rx_go;
   logic [DW-1:0]       rx_data;
   logic                rx_data_ready;
   logic [DW-1:0]       out_data;
   logic                out_valid;
   logic                out_ready;
   logic [CW-1:0]       count;
   logic                overrun;
   logic                overrun_clr;
   uart_rx_fifo_state_e dbg_state;
`ifdef UART_RX_FIFO_DROP_CNT_EN
   logic [7:0]          drop_count;
`endif

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] exp_q[$];

   uart_rx_fifo #(
      .Depth     (Depth),
      .DataWidth (DW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_go         (rx_go),
      .rx_data       (rx_data),
      .rx_data_ready (rx_data_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .count         (count),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr),
`ifdef UART_RX_FIFO_DROP_CNT_EN
      .drop_count    (drop_count),
`endif
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // One clock; a pop occurring at this edge is scored against the expected queue.
   task automatic tick();
      logic [DW-1:0] e;
      if (out_valid && out_ready) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         chk("pop_data", 32'(out_data), 32'(e));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pop_n(input int n);
      out_ready = 1'b1;
      repeat (n) tick();
      out_ready = 1'b0;
   endtask

   // Receiver model: present a byte once armed, release ready after the acknowledge.
   task automatic send_byte(input logic [DW-1:0] b, input bit exp_push);
      int n = 0;
      while (!rx_go && n < 50) begin
         tick();
         n++;
      end
      chk("go_armed", 32'(rx_go), 32'd1);
      rx_data       = b;
      rx_data_ready = 1'b1;
      if (exp_push) exp_q.push_back(b);
      tick();
      chk("ack_low", 32'(rx_go), 32'd0);
      rx_data_ready = 1'b0;
      rx_data       = '0;
      tick();
      chk("rearm", 32'(rx_go), 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      rx_data       = '0;
      rx_data_ready = 1'b0;
      out_ready     = 1'b0;
      overrun_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_go", 32'(rx_go), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(Init));
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("rst_drop_cnt", 32'(drop_count), 32'd0);
`endif

      // rx_go rises exactly one cycle after reset release
      rst = 1'b0;
      chk("go_pre", 32'(rx_go), 32'd0);
      tick();
      chk("go_first", 32'(rx_go), 32'd1);
      chk("state_arm", 32'(dbg_state), 32'(Arm));
      repeat (3) begin
         tick();
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_count", 32'(count), 32'd0);
      end

      // basic bytes through the handshake
      send_byte(8'h55, 1'b1);
      send_byte(8'hA3, 1'b1);
      send_byte(8'h00, 1'b1);
      chk("basic_count", 32'(count), 32'd3);
      chk("basic_head", 32'(out_data), 32'h55);
      pop_n(3);
      chk("basic_empty", 32'(out_valid), 32'd0);

      // fill past capacity with no consumer
      for (int i = 1; i <= 6; i++) send_byte(8'(i), i <= Depth);
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_overrun", 32'(overrun), 32'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("fill_drop_cnt", 32'(drop_count), 32'd2);
`endif
      pop_n(4);
      chk("fill_drained", 32'(count), 32'd0);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("clr_overrun", 32'(overrun), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("clr_drop_cnt", 32'(drop_count), 32'd0);
`endif

      // push and pop in the same cycle
      send_byte(8'h21, 1'b1);
      send_byte(8'h22, 1'b1);
      chk("sim_pre_count", 32'(count), 32'd2);
      rx_data       = 8'h23;
      rx_data_ready = 1'b1;
      out_ready     = 1'b1;
      exp_q.push_back(8'h23);
      tick();
      out_ready = 1'b0;
      chk("sim_count", 32'(count), 32'd2);
      chk("sim_head", 32'(out_data), 32'h22);
      chk("sim_ack", 32'(rx_go), 32'd0);
      rx_data_ready = 1'b0;
      tick();
      chk("sim_rearm", 32'(rx_go), 32'd1);
      pop_n(2);
      chk("sim_empty", 32'(count), 32'd0);

      // drop and clear in the same cycle: set wins
      for (int i = 0; i < Depth; i++) send_byte(8'(8'h31 + i), 1'b1);
      chk("full_count", 32'(count), 32'd4);
      rx_data       = 8'h35;
      rx_data_ready = 1'b1;
      overrun_clr   = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("setclr_overrun", 32'(overrun), 32'd1);
      chk("setclr_count", 32'(count), 32'd4);
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("setclr_drop_cnt", 32'(drop_count), 32'd1);
`endif
      rx_data_ready = 1'b0;
      rx_data       = '0;
      tick();
      chk("setclr_rearm", 32'(rx_go), 32'd1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("late_clr", 32'(overrun), 32'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
      chk("late_clr_cnt", 32'(drop_count), 32'd0);
`endif
      pop_n(4);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // popping an empty FIFO has no effect
      out_ready = 1'b1;
      tick();
      tick();
      chk("underflow_count", 32'(count), 32'd0);
      chk("underflow_valid", 32'(out_valid), 32'd0);

      // wrap-around with continuous consumer
      for (int i = 0; i < 3 * Depth; i++) send_byte(8'(8'h10 + i), 1'b1);
      tick();
      out_ready = 1'b0;
      chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("wrap_count", 32'(count), 32'd0);
      chk("wrap_overrun", 32'(overrun), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
